// File: rtl/pe_grid_pkg.sv
// Shared types and defaults for the pe_grid systolic MAC array.
package pe_grid_pkg;

  localparam int unsigned DEF_ROWS   = 16;
  localparam int unsigned DEF_COLS   = 16;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ACC_W  = 32;
  localparam int unsigned DEF_KLEN_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Index width that stays at least one bit for single-entry dimensions
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pe_grid_if.sv
// Job, operand-stream and readout signal bundle for pe_grid.
interface pe_grid_if #(
  parameter int unsigned ROWS   = pe_grid_pkg::DEF_ROWS,
  parameter int unsigned COLS   = pe_grid_pkg::DEF_COLS,
  parameter int unsigned DATA_W = pe_grid_pkg::DEF_DATA_W,
  parameter int unsigned ACC_W  = pe_grid_pkg::DEF_ACC_W,
  parameter int unsigned KLEN_W = pe_grid_pkg::DEF_KLEN_W
);
  import pe_grid_pkg::*;

  logic                          start;
  logic [KLEN_W-1:0]             k_len;
  logic                          in_valid;
  logic                          in_ready;
  logic [ROWS*DATA_W-1:0]        x_data;
  logic [COLS*DATA_W-1:0]        y_data;
  logic                          busy;
  logic                          done;
  logic                          rd_en;
  logic [idx_w(ROWS)-1:0]        rd_row;
  logic [idx_w(COLS)-1:0]        rd_col;
  logic [ACC_W-1:0]              rd_data;
  logic                          rd_valid;

  modport master (
    output start, k_len, in_valid, x_data, y_data, rd_en, rd_row, rd_col,
    input  in_ready, busy, done, rd_data, rd_valid
  );

  modport slave (
    input  start, k_len, in_valid, x_data, y_data, rd_en, rd_row, rd_col,
    output in_ready, busy, done, rd_data, rd_valid
  );

endinterface

// File: rtl/pe_mac.sv
// One processing element: forwards x east and y south, accumulates x*y when both are valid.
module pe_mac import pe_grid_pkg::*; #(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ACC_W  = DEF_ACC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] y,
  input  logic              xv,
  input  logic              yv,
  output logic [DATA_W-1:0] x_fwd,
  output logic [DATA_W-1:0] y_fwd,
  output logic              xv_fwd,
  output logic              yv_fwd,
  output logic [ACC_W-1:0]  acc
);

  // Operands narrowed first: low ACC_W bits of the product are unchanged
  logic [ACC_W-1:0] prod_c;
  assign prod_c = ACC_W'(x) * ACC_W'(y);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_fwd  <= '0;
      y_fwd  <= '0;
      xv_fwd <= 1'b0;
      yv_fwd <= 1'b0;
      acc    <= '0;
    end else begin
      x_fwd  <= x;
      y_fwd  <= y;
      xv_fwd <= xv;
      yv_fwd <= yv;
      if (clr)
        acc <= '0;
      else if (xv && yv)
        acc <= acc + prod_c;
    end
  end

endmodule

// File: rtl/pe_grid.sv
// ROWS x COLS output-stationary systolic MAC array with job FSM, input skew and readout port.
module pe_grid import pe_grid_pkg::*; #(
  parameter int unsigned ROWS   = DEF_ROWS,
  parameter int unsigned COLS   = DEF_COLS,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ACC_W  = DEF_ACC_W,
  parameter int unsigned KLEN_W = DEF_KLEN_W
) (
  input  logic                   master_clock,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [KLEN_W-1:0]      k_len,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ROWS*DATA_W-1:0] x_data,
  input  logic [COLS*DATA_W-1:0] y_data,
  output logic                   busy,
  output logic                   done,
  input  logic                   rd_en,
  input  logic [idx_w(ROWS)-1:0] rd_row,
  input  logic [idx_w(COLS)-1:0] rd_col,
  output logic [ACC_W-1:0]       rd_data,
  output logic                   rd_valid
);

  localparam int unsigned DRAIN_LEN = ROWS + COLS - 1;
  localparam int unsigned DRAIN_W   = idx_w(ROWS + COLS);

  state_t              state, state_n;
  logic [KLEN_W-1:0]   k_q, k_n, beat_q, beat_n;
  logic [DRAIN_W-1:0]  drain_q, drain_n;
  logic                clr_c, accept_c;

  assign accept_c = in_valid & in_ready;

  // Job sequencing
  always_comb begin
    state_n = state;
    k_n     = k_q;
    beat_n  = beat_q;
    drain_n = drain_q;
    clr_c   = 1'b0;
    case (state)
      IDLE: if (start) begin
        clr_c   = 1'b1;
        k_n     = k_len;
        beat_n  = '0;
        drain_n = '0;
        state_n = (k_len == '0) ? DONE : FEED;
      end
      FEED: if (accept_c) begin
        beat_n = beat_q + KLEN_W'(1);
        if (beat_n == k_q) state_n = DRAIN;
      end
      DRAIN: begin
        if (drain_q == DRAIN_W'(DRAIN_LEN - 1)) state_n = DONE;
        else                                    drain_n = drain_q + DRAIN_W'(1);
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge master_clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      k_q      <= '0;
      beat_q   <= '0;
      drain_q  <= '0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      k_q      <= k_n;
      beat_q   <= beat_n;
      drain_q  <= drain_n;
      in_ready <= (state_n == FEED);
      busy     <= (state_n == FEED) || (state_n == DRAIN);
      done     <= (state_n == DONE);
    end
  end

  logic [DATA_W-1:0] x_lane [ROWS];
  logic              xv_lane[ROWS];
  logic [DATA_W-1:0] y_lane [COLS];
  logic              yv_lane[COLS];

  // Lane i of x is delayed by i stages so beat k meets its y partner at PE(i,j)
  for (genvar i = 0; i < ROWS; i++) begin : g_xskew
    if (i == 0) begin : g_direct
      assign x_lane[i]  = x_data[i*DATA_W +: DATA_W];
      assign xv_lane[i] = accept_c;
    end else begin : g_chain
      logic [DATA_W-1:0] d [i];
      logic              v [i];
      always_ff @(posedge master_clock or negedge reset_n) begin
        if (!reset_n) begin
          for (int s = 0; s < i; s++) begin
            d[s] <= '0;
            v[s] <= 1'b0;
          end
        end else begin
          d[0] <= x_data[i*DATA_W +: DATA_W];
          v[0] <= accept_c;
          for (int s = 1; s < i; s++) begin
            d[s] <= d[s-1];
            v[s] <= v[s-1];
          end
        end
      end
      assign x_lane[i]  = d[i-1];
      assign xv_lane[i] = v[i-1];
    end
  end

  for (genvar j = 0; j < COLS; j++) begin : g_yskew
    if (j == 0) begin : g_direct
      assign y_lane[j]  = y_data[j*DATA_W +: DATA_W];
      assign yv_lane[j] = accept_c;
    end else begin : g_chain
      logic [DATA_W-1:0] d [j];
      logic              v [j];
      always_ff @(posedge master_clock or negedge reset_n) begin
        if (!reset_n) begin
          for (int s = 0; s < j; s++) begin
            d[s] <= '0;
            v[s] <= 1'b0;
          end
        end else begin
          d[0] <= y_data[j*DATA_W +: DATA_W];
          v[0] <= accept_c;
          for (int s = 1; s < j; s++) begin
            d[s] <= d[s-1];
            v[s] <= v[s-1];
          end
        end
      end
      assign y_lane[j]  = d[j-1];
      assign yv_lane[j] = v[j-1];
    end
  end

  logic [DATA_W-1:0] xd  [ROWS][COLS+1];
  logic              xvd [ROWS][COLS+1];
  logic [DATA_W-1:0] yd  [ROWS+1][COLS];
  logic              yvd [ROWS+1][COLS];
  logic [ACC_W-1:0]  acc [ROWS][COLS];

  for (genvar i = 0; i < ROWS; i++) begin : g_row
    assign xd[i][0]  = x_lane[i];
    assign xvd[i][0] = xv_lane[i];
  end
  for (genvar j = 0; j < COLS; j++) begin : g_col
    assign yd[0][j]  = y_lane[j];
    assign yvd[0][j] = yv_lane[j];
  end

  for (genvar i = 0; i < ROWS; i++) begin : g_pe_r
    for (genvar j = 0; j < COLS; j++) begin : g_pe_c
      pe_mac #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
        .clk    (master_clock),
        .rst_n  (reset_n),
        .clr    (clr_c),
        .x      (xd[i][j]),
        .y      (yd[i][j]),
        .xv     (xvd[i][j]),
        .yv     (yvd[i][j]),
        .x_fwd  (xd[i][j+1]),
        .y_fwd  (yd[i+1][j]),
        .xv_fwd (xvd[i][j+1]),
        .yv_fwd (yvd[i+1][j]),
        .acc    (acc[i][j])
      );
    end
  end

  // Readout; out-of-range indices still answer, with zero
  always_ff @(posedge master_clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en)
        rd_data <= (32'(rd_row) < ROWS && 32'(rd_col) < COLS) ? acc[rd_row][rd_col] : '0;
    end
  end

endmodule

// File: tb/tb_pe_grid.sv
// Scenario bench for pe_grid: 2x2 dot-product jobs, 4x4 truncation, 3x3 edge cases, mid-job reset.
module tb_pe_grid;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] exp_q[$];
  logic [31:0] xs[2][2];
  logic [31:0] ys[2][2];
  logic [31:0] m2[2][2];

  pe_grid_if #(.ROWS(2), .COLS(2), .DATA_W(32), .ACC_W(32), .KLEN_W(8)) b2();
  pe_grid_if #(.ROWS(4), .COLS(4), .DATA_W(32), .ACC_W(32), .KLEN_W(8)) b4();
  pe_grid_if #(.ROWS(3), .COLS(3), .DATA_W(32), .ACC_W(32), .KLEN_W(8)) b3();

  pe_grid #(.ROWS(2), .COLS(2), .DATA_W(32), .ACC_W(32), .KLEN_W(8)) dut2 (
    .master_clock(clk), .reset_n(rst_n), .start(b2.start), .k_len(b2.k_len),
    .in_valid(b2.in_valid), .in_ready(b2.in_ready), .x_data(b2.x_data), .y_data(b2.y_data),
    .busy(b2.busy), .done(b2.done), .rd_en(b2.rd_en), .rd_row(b2.rd_row), .rd_col(b2.rd_col),
    .rd_data(b2.rd_data), .rd_valid(b2.rd_valid));

  pe_grid #(.ROWS(4), .COLS(4), .DATA_W(32), .ACC_W(32), .KLEN_W(8)) dut4 (
    .master_clock(clk), .reset_n(rst_n), .start(b4.start), .k_len(b4.k_len),
    .in_valid(b4.in_valid), .in_ready(b4.in_ready), .x_data(b4.x_data), .y_data(b4.y_data),
    .busy(b4.busy), .done(b4.done), .rd_en(b4.rd_en), .rd_row(b4.rd_row), .rd_col(b4.rd_col),
    .rd_data(b4.rd_data), .rd_valid(b4.rd_valid));

  pe_grid #(.ROWS(3), .COLS(3), .DATA_W(32), .ACC_W(32), .KLEN_W(8)) dut3 (
    .master_clock(clk), .reset_n(rst_n), .start(b3.start), .k_len(b3.k_len),
    .in_valid(b3.in_valid), .in_ready(b3.in_ready), .x_data(b3.x_data), .y_data(b3.y_data),
    .busy(b3.busy), .done(b3.done), .rd_en(b3.rd_en), .rd_row(b3.rd_row), .rd_col(b3.rd_col),
    .rd_data(b3.rd_data), .rd_valid(b3.rd_valid));

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  // 2x2 job of two beats from xs/ys; gap = idle cycles between beats
  task automatic job2(input int gap, input bit peek, input bit prestarted, input string tag);
    int n, t0, t1;
    logic [31:0] e;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        m2[i][j] = xs[0][i] * ys[0][j] + xs[1][i] * ys[1][j];
    t0 = 0;
    if (!prestarted) begin
      @(posedge clk); #1 b2.start = 1'b1; b2.k_len = 8'd2;
      @(posedge clk); #1 b2.start = 1'b0; t0 = cyc;
    end
    checks++;
    if (b2.in_ready !== 1'b1) begin errors++; $display("FAIL %s_feed_ready got %0b want 1", tag, b2.in_ready); end
    for (int k = 0; k < 2; k++) begin
      b2.in_valid = 1'b1;
      b2.x_data = {xs[k][1], xs[k][0]};
      b2.y_data = {ys[k][1], ys[k][0]};
      @(posedge clk); #1 b2.in_valid = 1'b0;
      if (k == 0) repeat (gap) begin @(posedge clk); #1; end
    end
    checks++;
    if (b2.in_ready !== 1'b0 || b2.busy !== 1'b1)
      begin errors++; $display("FAIL %s_drain_flags got ready=%0b busy=%0b want 0/1", tag, b2.in_ready, b2.busy); end
    if (peek) begin
      b2.rd_en = 1'b1; b2.rd_row = 1'b0; b2.rd_col = 1'b0;
      exp_q.push_back(m2[0][0]);
    end
    n = 0;
    while (b2.done !== 1'b1 && n < 40) begin
      @(posedge clk); #1 n++;
      if (peek && n == 1) begin
        b2.rd_en = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (b2.rd_valid !== 1'b1 || b2.rd_data !== e)
          begin errors++; $display("FAIL %s_busy_read got v=%0b d=%0d want 1/%0d", tag, b2.rd_valid, b2.rd_data, e); end
      end
    end
    t1 = cyc;
    checks++;
    if (n != 3) begin errors++; $display("FAIL %s_done_after_last_beat got %0d want 3", tag, n); end
    if (!prestarted) begin
      checks++;
      if (t1 - t0 != 5 + gap) begin errors++; $display("FAIL %s_done_after_start got %0d want %0d", tag, t1 - t0, 5 + gap); end
    end
    checks++;
    if (b2.busy !== 1'b0) begin errors++; $display("FAIL %s_busy_at_done got %0b want 0", tag, b2.busy); end
    @(posedge clk); #1;
    checks++;
    if (b2.done !== 1'b0) begin errors++; $display("FAIL %s_done_pulse got %0b want 0", tag, b2.done); end
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        exp_q.push_back(m2[i][j]);
        b2.rd_en = 1'b1; b2.rd_row = 1'(i); b2.rd_col = 1'(j);
        @(posedge clk); #1 b2.rd_en = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (b2.rd_valid !== 1'b1 || b2.rd_data !== e)
          begin errors++; $display("FAIL %s_acc%0d%0d got v=%0b d=%0d want 1/%0d", tag, i, j, b2.rd_valid, b2.rd_data, e); end
      end
    end
    @(posedge clk); #1;
    checks++;
    if (b2.rd_valid !== 1'b0) begin errors++; $display("FAIL %s_rd_valid_idle got %0b want 0", tag, b2.rd_valid); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    b2.start = 0; b2.k_len = 0; b2.in_valid = 0; b2.x_data = '0; b2.y_data = '0; b2.rd_en = 0; b2.rd_row = 0; b2.rd_col = 0;
    b4.start = 0; b4.k_len = 0; b4.in_valid = 0; b4.x_data = '0; b4.y_data = '0; b4.rd_en = 0; b4.rd_row = 0; b4.rd_col = 0;
    b3.start = 0; b3.k_len = 0; b3.in_valid = 0; b3.x_data = '0; b3.y_data = '0; b3.rd_en = 0; b3.rd_row = 0; b3.rd_col = 0;
    repeat (2) @(posedge clk); #1;
    checks++; if (b2.busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got %0b want 0", b2.busy); end
    checks++; if (b2.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %0b want 0", b2.in_ready); end
    checks++; if (b2.done !== 1'b0)     begin errors++; $display("FAIL reset_done got %0b want 0", b2.done); end
    checks++; if (b2.rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %0b want 0", b2.rd_valid); end
    checks++; if (b2.rd_data !== 32'd0) begin errors++; $display("FAIL reset_rd_data got %0d want 0", b2.rd_data); end
    checks++; if (b4.busy !== 1'b0 || b3.in_ready !== 1'b0)
      begin errors++; $display("FAIL reset_others got busy4=%0b ready3=%0b want 0/0", b4.busy, b3.in_ready); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    xs = '{'{32'd1, 32'd2}, '{32'd5, 32'd6}};
    ys = '{'{32'd3, 32'd4}, '{32'd7, 32'd8}};
    job2(0, 1'b0, 1'b0, "basic");
  endtask

  task automatic test_bubbles();
    xs = '{'{32'd1, 32'd2}, '{32'd5, 32'd6}};
    ys = '{'{32'd3, 32'd4}, '{32'd7, 32'd8}};
    job2(3, 1'b0, 1'b0, "bubble");
  endtask

  task automatic test_busy_read();
    for (int k = 0; k < 2; k++)
      for (int l = 0; l < 2; l++) begin
        xs[k][l] = $urandom;
        ys[k][l] = $urandom;
      end
    job2(0, 1'b1, 1'b0, "random");
  endtask

  task automatic test_truncation();
    int n;
    logic [31:0] e;
    @(posedge clk); #1 b4.start = 1'b1; b4.k_len = 8'd1;
    @(posedge clk); #1 b4.start = 1'b0;
    b4.in_valid = 1'b1; b4.x_data = {4{32'hFFFF_FFFF}}; b4.y_data = {4{32'hFFFF_FFFF}};
    @(posedge clk); #1 b4.in_valid = 1'b0;
    n = 0;
    while (b4.done !== 1'b1 && n < 40) begin @(posedge clk); #1 n++; end
    checks++;
    if (n != 7) begin errors++; $display("FAIL trunc_done_latency got %0d want 7", n); end
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        exp_q.push_back(32'h0000_0001);
        b4.rd_en = 1'b1; b4.rd_row = 2'(i); b4.rd_col = 2'(j);
        @(posedge clk); #1 b4.rd_en = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (b4.rd_valid !== 1'b1 || b4.rd_data !== e)
          begin errors++; $display("FAIL trunc_acc%0d%0d got v=%0b d=%h want 1/%h", i, j, b4.rd_valid, b4.rd_data, e); end
      end
    end
  endtask

  task automatic test_kzero_busy();
    int n;
    logic [31:0] e;
    // Non-zero job first so the k_len=0 clear is observable
    @(posedge clk); #1 b3.start = 1'b1; b3.k_len = 8'd1;
    @(posedge clk); #1 b3.start = 1'b0;
    b3.in_valid = 1'b1; b3.x_data = {32'd4, 32'd3, 32'd2}; b3.y_data = {32'd7, 32'd6, 32'd5};
    @(posedge clk); #1 b3.in_valid = 1'b0;
    n = 0;
    while (b3.done !== 1'b1 && n < 40) begin @(posedge clk); #1 n++; end
    checks++;
    if (n != 5) begin errors++; $display("FAIL g3_done_latency got %0d want 5", n); end
    exp_q.push_back(32'd28);
    b3.rd_en = 1'b1; b3.rd_row = 2'd2; b3.rd_col = 2'd2;
    @(posedge clk); #1 b3.rd_en = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (b3.rd_data !== e) begin errors++; $display("FAIL g3_acc22 got %0d want %0d", b3.rd_data, e); end

    @(posedge clk); #1 b3.start = 1'b1; b3.k_len = 8'd0;
    @(posedge clk); #1 b3.start = 1'b0;
    checks++;
    if (b3.done !== 1'b1 || b3.busy !== 1'b0)
      begin errors++; $display("FAIL kzero_done got done=%0b busy=%0b want 1/0", b3.done, b3.busy); end
    @(posedge clk); #1;
    checks++;
    if (b3.done !== 1'b0) begin errors++; $display("FAIL kzero_done_pulse got %0b want 0", b3.done); end
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        exp_q.push_back(32'd0);
        b3.rd_en = 1'b1; b3.rd_row = 2'(i); b3.rd_col = 2'(j);
        @(posedge clk); #1 b3.rd_en = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (b3.rd_valid !== 1'b1 || b3.rd_data !== e)
          begin errors++; $display("FAIL kzero_acc%0d%0d got v=%0b d=%0d want 1/%0d", i, j, b3.rd_valid, b3.rd_data, e); end
      end
    end

    // A second start while in FEED must not relatch k_len or clear
    @(posedge clk); #1 b3.start = 1'b1; b3.k_len = 8'd1;
    @(posedge clk); #1 b3.k_len = 8'd3;
    b3.in_valid = 1'b1; b3.x_data = {3{32'd1}}; b3.y_data = {3{32'd1}};
    @(posedge clk); #1 b3.start = 1'b0; b3.in_valid = 1'b0;
    checks++;
    if (b3.busy !== 1'b1 || b3.in_ready !== 1'b0)
      begin errors++; $display("FAIL ignore_start_state got busy=%0b ready=%0b want 1/0", b3.busy, b3.in_ready); end
    n = 0;
    while (b3.done !== 1'b1 && n < 40) begin @(posedge clk); #1 n++; end
    checks++;
    if (n != 5) begin errors++; $display("FAIL ignore_start_done got %0d want 5", n); end
    exp_q.push_back(32'd1);
    b3.rd_en = 1'b1; b3.rd_row = 2'd2; b3.rd_col = 2'd2;
    @(posedge clk); #1 b3.rd_en = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (b3.rd_data !== e) begin errors++; $display("FAIL ignore_start_acc22 got %0d want %0d", b3.rd_data, e); end

    exp_q.push_back(32'd0);
    b3.rd_en = 1'b1; b3.rd_row = 2'd3; b3.rd_col = 2'd0;
    @(posedge clk); #1 b3.rd_en = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (b3.rd_valid !== 1'b1 || b3.rd_data !== e)
      begin errors++; $display("FAIL oob_row got v=%0b d=%0d want 1/%0d", b3.rd_valid, b3.rd_data, e); end
    exp_q.push_back(32'd0);
    b3.rd_en = 1'b1; b3.rd_row = 2'd0; b3.rd_col = 2'd3;
    @(posedge clk); #1 b3.rd_en = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (b3.rd_valid !== 1'b1 || b3.rd_data !== e)
      begin errors++; $display("FAIL oob_col got v=%0b d=%0d want 1/%0d", b3.rd_valid, b3.rd_data, e); end
  endtask

  task automatic test_reset_mid();
    int n;
    logic [31:0] e;
    xs = '{'{32'd9, 32'd3}, '{32'd2, 32'd7}};
    ys = '{'{32'd4, 32'd1}, '{32'd6, 32'd5}};
    @(posedge clk); #1 b2.start = 1'b1; b2.k_len = 8'd2;
    @(posedge clk); #1 b2.start = 1'b0;
    b2.in_valid = 1'b1; b2.x_data = {xs[0][1], xs[0][0]}; b2.y_data = {ys[0][1], ys[0][0]};
    @(posedge clk); #1 b2.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (b2.busy !== 1'b0 || b2.in_ready !== 1'b0)
      begin errors++; $display("FAIL midreset_flags got busy=%0b ready=%0b want 0/0", b2.busy, b2.in_ready); end
    n = 0;
    repeat (3) begin @(posedge clk); #1 if (b2.done !== 1'b0) n++; end
    checks++;
    if (n != 0) begin errors++; $display("FAIL midreset_no_done got %0d pulses want 0", n); end
    // Release just before an edge with start and a readout already asserted
    b2.start = 1'b1; b2.k_len = 8'd2;
    b2.rd_en = 1'b1; b2.rd_row = 1'b0; b2.rd_col = 1'b0;
    exp_q.push_back(32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1 b2.start = 1'b0; b2.rd_en = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (b2.rd_valid !== 1'b1 || b2.rd_data !== e)
      begin errors++; $display("FAIL midreset_acc_cleared got v=%0b d=%0d want 1/%0d", b2.rd_valid, b2.rd_data, e); end
    checks++;
    if (b2.busy !== 1'b1) begin errors++; $display("FAIL midreset_first_edge_start got busy=%0b want 1", b2.busy); end
    job2(0, 1'b0, 1'b1, "fresh");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bubbles();
    test_busy_read();
    test_truncation();
    test_kzero_busy();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
